// File: rtl/codor_cezar_enc.sv
// codor_cezar_enc: registered Caesar-cipher byte encoder.
// Letters 'a'..'z' / 'A'..'Z' are rotated by the key register with case
// preserved; every other byte passes through unchanged. One cycle latency,
// one byte per clock, no backpressure.
// Build option: define CEZAR_DECODE_EN to add the per-byte `dec` input
// (0 = encode, 1 = decode). Without it the block only encodes.
module codor_cezar_enc #(
    parameter int SHIFT = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] in,
    input  logic       in_valid,
    input  logic       shift_ld,
    input  logic [4:0] shift_in,
`ifdef CEZAR_DECODE_EN
    input  logic       dec,
`endif
    output logic [7:0] out,
    output logic       out_valid,
    output logic [4:0] key
);

    // SHIFT is expected in 0..25; the low five bits hold any legal value.
    localparam logic [4:0] KEY_RST = 5'(SHIFT);

    logic       is_lower;
    logic       is_upper;
    logic       is_alpha;
    logic       do_dec;
    logic [7:0] base;
    logic [4:0] idx;
    logic [5:0] sum;
    logic [5:0] sum_wrapped;
    logic [7:0] result;
    logic [4:0] shift_red;

    // Classify the input byte and pick the alphabet base.
    always_comb begin
        is_lower = (in >= 8'h61) && (in <= 8'h7A);
        is_upper = (in >= 8'h41) && (in <= 8'h5A);
        is_alpha = is_lower || is_upper;
        base     = is_lower ? 8'h61 : 8'h41;
        idx      = 5'(in - base);
    end

    // Direction select; tied to encode when the decode option is not built.
`ifdef CEZAR_DECODE_EN
    always_comb do_dec = dec;
`else
    always_comb do_dec = 1'b0;
`endif

    // Rotate within 26 letters using a single conditional subtract.
    // Decode adds 26 first so the intermediate never goes negative (max 51).
    always_comb begin
        if (do_dec) begin
            sum = 6'(idx) + 6'd26 - 6'(key);
        end else begin
            sum = 6'(idx) + 6'(key);
        end
        sum_wrapped = (sum >= 6'd26) ? (sum - 6'd26) : sum;
        result      = is_alpha ? (base + {2'b00, sum_wrapped}) : in;
    end

    // Reduce a new key modulo 26; shift_in is at most 31 so one subtract suffices.
    always_comb begin
        shift_red = (shift_in >= 5'd26) ? (shift_in - 5'd26) : shift_in;
    end

    // Key register: new key takes effect on the cycle after shift_ld, so a
    // byte arriving alongside shift_ld still uses the old key.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key <= KEY_RST;
        end else if (shift_ld) begin
            key <= shift_red;
        end
    end

    // Output register: out holds its last result while no byte is valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= 8'h00;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out <= result;
            end
        end
    end

endmodule

// File: tb/tb_codor_cezar_enc.sv
// Bench for codor_cezar_enc: directed steps plus randomized traffic checked
// against an arithmetic reference model; a second instance checks that two
// copies fed identical stimulus agree every cycle.
module tb_codor_cezar_enc;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in;
    logic       in_valid;
    logic       shift_ld;
    logic [4:0] shift_in;
    logic       dec;
    logic [7:0] out_a, out_b;
    logic       out_valid_a, out_valid_b;
    logic [4:0] key_a, key_b;

    int tests = 0;
    int fails = 0;

    int         m_key;
    logic [7:0] m_out;
    logic       m_valid;

    always #5 clk = ~clk;

    codor_cezar_enc #(.SHIFT(3)) dut_a (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .shift_ld(shift_ld), .shift_in(shift_in),
`ifdef CEZAR_DECODE_EN
        .dec(dec),
`endif
        .out(out_a), .out_valid(out_valid_a), .key(key_a)
    );

    codor_cezar_enc #(.SHIFT(3)) dut_b (
        .clk(clk), .rst_n(rst_n), .in(in), .in_valid(in_valid),
        .shift_ld(shift_ld), .shift_in(shift_in),
`ifdef CEZAR_DECODE_EN
        .dec(dec),
`endif
        .out(out_b), .out_valid(out_valid_b), .key(key_b)
    );

    function automatic logic [7:0] ref_rot(input logic [7:0] c, input int k, input bit d);
        int b;
        if (c >= 8'h61 && c <= 8'h7A) b = 97;
        else if (c >= 8'h41 && c <= 8'h5A) b = 65;
        else return c;
        if (d) return 8'(b + ((int'(c) - b - k + 26) % 26));
        return 8'(b + ((int'(c) - b + k) % 26));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".out"}, 32'(out_a), 32'(m_out));
        check({tag, ".valid"}, 32'(out_valid_a), 32'(m_valid));
        check({tag, ".key"}, 32'(key_a), 32'(m_key));
        check({tag, ".twin"}, {15'd0, out_valid_b, key_b, out_b},
              {15'd0, out_valid_a, key_a, out_a});
    endtask

    // One clock: drive after the falling edge, update the model at the rising
    // edge, sample 1 ns later, return at the next falling edge.
    task automatic cycle(input string tag, input logic [7:0] b, input bit v,
                         input bit ld, input logic [4:0] si, input bit d);
        in       = b;
        in_valid = v;
        shift_ld = ld;
        shift_in = si;
        dec      = d;
        @(posedge clk);
        if (v) begin
            m_out   = ref_rot(b, m_key, d);
            m_valid = 1'b1;
        end else begin
            m_valid = 1'b0;
        end
        if (ld) m_key = int'(si) % 26;
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic enc(input string tag, input logic [7:0] b);
        cycle(tag, b, 1'b1, 1'b0, 5'd0, 1'b0);
    endtask

    task automatic load(input string tag, input logic [4:0] si);
        cycle(tag, 8'h00, 1'b0, 1'b1, si, 1'b0);
    endtask

    initial begin
        logic [7:0] pass_list[7];
        logic [7:0] r;
`ifdef CEZAR_DECODE_EN
        string      word;
        logic [7:0] ct[5];
`endif
        rst_n = 1'b0; in = 8'h00; in_valid = 1'b0; shift_ld = 1'b0;
        shift_in = 5'd0; dec = 1'b0;
        m_key = 3; m_out = 8'h00; m_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check_all("post_reset");

        // Basic stream, back-to-back.
        enc("a", 8'h61);
        check("a_lit", 32'(out_a), 32'h64);
        enc("m", 8'h6D);
        check("m_lit", 32'(out_a), 32'h70);
        enc("k", 8'h6B);
        check("k_lit", 32'(out_a), 32'h6E);
        cycle("idle_hold", 8'h55, 1'b0, 1'b0, 5'd0, 1'b0);

        // Wrap-around.
        enc("z", 8'h7A);
        check("z_lit", 32'(out_a), 32'h63);
        enc("Y", 8'h59);
        check("Y_lit", 32'(out_a), 32'h42);
        enc("x", 8'h78);
        load("ld25", 5'd25);
        enc("a_k25", 8'h61);
        check("a_k25_lit", 32'(out_a), 32'h7A);

        // Pass-through bytes, including neighbours of the letter ranges.
        pass_list = '{8'h35, 8'h20, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'hFF};
        foreach (pass_list[i]) begin
            enc("pass", pass_list[i]);
            check("pass_lit", 32'(out_a), 32'(pass_list[i]));
        end

        // Key load boundaries.
        load("ld26", 5'd26);
        check("ld26_key", 32'(key_a), 32'd0);
        enc("q_k0", 8'h71);
        check("q_k0_lit", 32'(out_a), 32'h71);
        load("ld31", 5'd31);
        check("ld31_key", 32'(key_a), 32'd5);
        load("ld3", 5'd3);
        cycle("ld_same", 8'h61, 1'b1, 1'b1, 5'd1, 1'b0);
        check("ld_same_lit", 32'(out_a), 32'h64);
        enc("after_ld", 8'h61);
        check("after_ld_lit", 32'(out_a), 32'h62);

        // Reset between clock edges while a byte is being presented.
        load("ld9", 5'd9);
        in = 8'h61; in_valid = 1'b1;
        @(posedge clk);
        m_out = ref_rot(8'h61, m_key, 1'b0); m_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        m_key = 3; m_out = 8'h00; m_valid = 1'b0;
        check_all("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        enc("rel_a", 8'h61);
        check("rel_a_lit", 32'(out_a), 32'h64);

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            r = ($urandom_range(0, 2) == 0) ? 8'($urandom) :
                (($urandom_range(0, 1) == 0) ? 8'(8'h61 + $urandom_range(0, 25))
                                             : 8'(8'h41 + $urandom_range(0, 25)));
            cycle("rand", r, ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)), 1'b0);
        end

`ifdef CEZAR_DECODE_EN
        load("dld3", 5'd3);
        cycle("dec_d", 8'h64, 1'b1, 1'b0, 5'd0, 1'b1);
        check("dec_d_lit", 32'(out_a), 32'h61);
        cycle("dec_c", 8'h63, 1'b1, 1'b0, 5'd0, 1'b1);
        check("dec_c_lit", 32'(out_a), 32'h7A);
        word = "Cezar";
        for (int i = 0; i < 5; i++) begin
            enc("rt_enc", word[i]);
            ct[i] = out_a;
        end
        for (int i = 0; i < 5; i++) begin
            cycle("rt_dec", ct[i], 1'b1, 1'b0, 5'd0, 1'b1);
            check("rt_lit", 32'(out_a), 32'(word[i]));
        end
        for (int n = 0; n < 200; n++) begin
            cycle("rand_dec", 8'($urandom), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 7) == 0), 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
